// File: rtl/ps2_line_serializer_pkg.sv
// Shared line-format constants and FSM encoding for the PS/2 line serializer.
// The keyboard line assembler uses the same character layout.
package ps2_line_serializer_pkg;

    localparam int LINE_CHARS = 32;
    localparam int CHAR_W     = 8;
    localparam int LINE_W     = LINE_CHARS * CHAR_W;

    localparam logic [7:0] ASCII_NUL     = 8'h00;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0a;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_NL   = 2'd2,
        ST_DONE = 2'd3
    } ser_state_e;

    // Character idx of a packed line; char 0 sits in the top byte.
    function automatic logic [CHAR_W-1:0] line_char(input logic [LINE_W-1:0] line,
                                                    input int idx);
        return line[LINE_W-1-CHAR_W*idx -: CHAR_W];
    endfunction

endpackage

// File: rtl/ps2_line_serializer_if.sv
// Line-in / byte-out handshake bundle of the line serializer.
// master is the serializer side, slave is the line source plus byte sink.
interface ps2_line_serializer_if #(
    parameter int LINE_CHARS = 32,
    parameter int CHAR_W     = 8
);
    localparam int COUNT_W = $clog2(LINE_CHARS + 2);

    logic [LINE_CHARS*CHAR_W-1:0] line_content;
    logic                         line_valid;
    logic                         line_accept;
    logic [CHAR_W-1:0]            ascii_char;
    logic                         char_valid;
    logic                         char_ready;
    logic                         busy;
    logic                         line_done;
    logic [COUNT_W-1:0]           char_count;

    modport master (
        input  line_content, line_valid, char_ready,
        output line_accept, ascii_char, char_valid, busy, line_done, char_count
    );

    modport slave (
        output line_content, line_valid, char_ready,
        input  line_accept, ascii_char, char_valid, busy, line_done, char_count
    );

endinterface

// File: rtl/line_shift_register.sv
// Line holding register: parallel load of a whole line, shift left one character
// at a time with zero fill, top character always visible.
module line_shift_register #(
    parameter int LINE_CHARS = 32,
    parameter int CHAR_W     = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic                         shift,
    input  logic [LINE_CHARS*CHAR_W-1:0] load_data,
    output logic [CHAR_W-1:0]            top_char
);
    localparam int LINE_W = LINE_CHARS * CHAR_W;

    logic [LINE_W-1:0] data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {data[LINE_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
        end
    end

    assign top_char = data[LINE_W-1 -: CHAR_W];

endmodule

// File: rtl/ps2_line_serializer.sv
// Emits a packed text line one character per valid/ready transfer, stopping at
// the terminator and optionally appending a newline.
//
//  state | meaning
//  IDLE  | waiting for a line; line_accept high
//  SEND  | presenting top byte of the shift register; terminator ends text
//  NL    | presenting the appended newline
//  DONE  | one-cycle line_done pulse, then back to IDLE
module ps2_line_serializer
    import ps2_line_serializer_pkg::*;
#(
    parameter int              LINE_CHARS     = ps2_line_serializer_pkg::LINE_CHARS,
    parameter int              CHAR_W         = ps2_line_serializer_pkg::CHAR_W,
    parameter logic [CHAR_W-1:0] TERMINATOR   = ASCII_NUL,
    parameter logic [CHAR_W-1:0] NEWLINE      = ASCII_NEWLINE,
    parameter bit              APPEND_NEWLINE = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ps2_line_serializer_if.master bus
);
    localparam int COUNT_W = $clog2(LINE_CHARS + 2);
    localparam int IDX_W   = $clog2(LINE_CHARS);
    localparam ser_state_e AFTER_TEXT = APPEND_NEWLINE ? ST_NL : ST_DONE;

    ser_state_e         state, state_nxt;
    logic [CHAR_W-1:0]  top_char;
    logic [CHAR_W-1:0]  ascii_char_c;
    logic               char_valid_c;
    logic               shift_load, shift_en;
    logic               count_clr, count_inc;
    logic               left_load, left_dec;
    logic [COUNT_W-1:0] char_count;
    logic [IDX_W-1:0]   chars_left;

    line_shift_register #(
        .LINE_CHARS (LINE_CHARS),
        .CHAR_W     (CHAR_W)
    ) u_shift (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (shift_load),
        .shift     (shift_en),
        .load_data (bus.line_content),
        .top_char  (top_char)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_load   = 1'b0;
        shift_en     = 1'b0;
        count_clr    = 1'b0;
        count_inc    = 1'b0;
        left_load    = 1'b0;
        left_dec     = 1'b0;
        ascii_char_c = '0;
        char_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.line_valid) begin
                    shift_load = 1'b1;
                    count_clr  = 1'b1;
                    left_load  = 1'b1;
                    state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                ascii_char_c = top_char;
                // Terminator costs one bubble cycle; whatever follows it is dropped.
                if (top_char == TERMINATOR) begin
                    state_nxt = AFTER_TEXT;
                end else begin
                    char_valid_c = 1'b1;
                    if (bus.char_ready) begin
                        shift_en  = 1'b1;
                        count_inc = 1'b1;
                        if (chars_left == '0) begin
                            state_nxt = AFTER_TEXT;
                        end else begin
                            left_dec = 1'b1;
                        end
                    end
                end
            end
            ST_NL: begin
                ascii_char_c = NEWLINE;
                char_valid_c = 1'b1;
                if (bus.char_ready) begin
                    count_inc = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // chars_left counts down the remaining character slots; zero marks the last one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chars_left <= '0;
            char_count <= '0;
        end else begin
            if (left_load) begin
                chars_left <= IDX_W'(LINE_CHARS - 1);
            end else if (left_dec) begin
                chars_left <= chars_left - IDX_W'(1);
            end
            if (count_clr) begin
                char_count <= '0;
            end else if (count_inc) begin
                char_count <= char_count + COUNT_W'(1);
            end
        end
    end

    assign bus.line_accept = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.line_done   = (state == ST_DONE);
    assign bus.ascii_char  = ascii_char_c;
    assign bus.char_valid  = char_valid_c;
    assign bus.char_count  = char_count;

endmodule

// File: tb/tb_ps2_line_serializer.sv
// Scoreboard bench for ps2_line_serializer: expected bytes are queued from a line
// model when a line is offered and popped on every observed byte transfer.
module tb_ps2_line_serializer;
    import ps2_line_serializer_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    ps2_line_serializer_if bus ();
    ps2_line_serializer_if bus_nn ();

    ps2_line_serializer #(.APPEND_NEWLINE(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ps2_line_serializer #(.APPEND_NEWLINE(1'b0)) dut_nn (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_nn)
    );

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         nn_valid_cnt = 0;
    int         nn_done_cnt = 0;
    bit         ready_toggle = 1'b0;
    int         ready_phase = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_char = 8'h00;

    localparam logic [255:0] LINE_V42   = {8'h56, 8'h3D, 8'h34, 8'h32, 224'h0};
    localparam logic [255:0] LINE_A7    = {8'h41, 8'h3D, 8'h37, 232'h0};
    localparam logic [255:0] LINE_ANGLE = {"ANGLE=30", 192'h0};
    localparam logic [255:0] LINE_ALLA  = {32{8'h41}};
    localparam logic [255:0] LINE_ZERO  = 256'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: text up to the first NUL (max 32 chars), then optional newline.
    function automatic int push_line(input logic [255:0] line, input bit nl);
        int         n;
        logic [7:0] c;
        n = 0;
        for (int i = 0; i < LINE_CHARS; i++) begin
            c = line_char(line, i);
            if (c == ASCII_NUL) break;
            exp_q.push_back(c);
            n++;
        end
        if (nl) exp_q.push_back(ASCII_NEWLINE);
        return n;
    endfunction

    // Negedges from the first SEND cycle to the line_done cycle, sink always ready.
    function automatic int done_latency(input int n_text);
        return n_text + ((n_text < LINE_CHARS) ? 1 : 0) + 1 + 1;
    endfunction

    initial begin : ready_drv
        bus.char_ready    = 1'b1;
        bus_nn.char_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (ready_toggle) begin
                bus.char_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                ready_phase++;
            end else begin
                bus.char_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (prev_stall) begin
                    check_eq("hold_valid", 64'(bus.char_valid), 64'(1));
                    check_eq("hold_char", 64'(bus.ascii_char), 64'(prev_char));
                end
                if (bus.char_valid && bus.char_ready) begin
                    if (exp_q.size() == 0) check_eq("sb_depth", 64'(exp_q.size()), 64'(1));
                    else check_eq("char", 64'(bus.ascii_char), 64'(exp_q.pop_front()));
                end
                if (bus.line_done) done_cnt++;
                prev_stall = bus.char_valid && !bus.char_ready;
                prev_char  = bus.ascii_char;
                if (bus_nn.char_valid) nn_valid_cnt++;
                if (bus_nn.line_done) nn_done_cnt++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at the first SEND negedge (k=1) after the line is accepted.
    task automatic offer(input logic [255:0] line);
        int g;
        g = 0;
        @(negedge clock);
        while (!bus.line_accept && g < 200) begin
            @(negedge clock);
            g++;
        end
        check_eq("accept_ready", 64'(bus.line_accept), 64'(1));
        bus.line_content = line;
        bus.line_valid   = 1'b1;
        @(negedge clock);
        bus.line_valid   = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 1;
        while (!bus.line_done && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check_eq("done_seen", 64'(bus.line_done), 64'(1));
    endtask

    task automatic finish_line(input int exp_cnt, input int exp_k, input bit chk_k);
        int k;
        wait_done(k);
        if (chk_k) check_eq("done_latency", 64'(k), 64'(exp_k));
        check_eq("char_count", 64'(bus.char_count), 64'(exp_cnt));
        check_eq("accept_in_done", 64'(bus.line_accept), 64'(0));
        @(negedge clock);
        check_eq("done_pulse", 64'(bus.line_done), 64'(0));
        check_eq("idle_accept", 64'(bus.line_accept), 64'(1));
        check_eq("idle_busy", 64'(bus.busy), 64'(0));
        check_eq("count_hold", 64'(bus.char_count), 64'(exp_cnt));
        check_eq("sb_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : main
        int n;
        int k;
        int d0;
        bus.line_valid      = 1'b0;
        bus.line_content    = '0;
        bus_nn.line_valid   = 1'b0;
        bus_nn.line_content = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_accept", 64'(bus.line_accept), 64'(1));
        check_eq("rst_valid", 64'(bus.char_valid), 64'(0));
        check_eq("rst_char", 64'(bus.ascii_char), 64'(0));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_done", 64'(bus.line_done), 64'(0));
        check_eq("rst_count", 64'(bus.char_count), 64'(0));
        reset_n = 1'b1;

        // "V=42", sink always ready
        n = push_line(LINE_V42, 1'b1);
        offer(LINE_V42);
        check_eq("t1_first_char", 64'(bus.ascii_char), 64'(8'h56));
        check_eq("t1_first_valid", 64'(bus.char_valid), 64'(1));
        check_eq("t1_busy", 64'(bus.busy), 64'(1));
        finish_line(5, done_latency(n), 1'b1);

        // same line, stalling sink
        ready_toggle = 1'b1;
        ready_phase  = 0;
        n = push_line(LINE_V42, 1'b1);
        offer(LINE_V42);
        finish_line(5, 0, 1'b0);
        ready_toggle = 1'b0;

        // 32 non-NUL characters
        n = push_line(LINE_ALLA, 1'b1);
        offer(LINE_ALLA);
        check_eq("t3_accept_low", 64'(bus.line_accept), 64'(0));
        finish_line(33, done_latency(n), 1'b1);

        // all-NUL line
        n = push_line(LINE_ZERO, 1'b1);
        offer(LINE_ZERO);
        check_eq("t4_bubble", 64'(bus.char_valid), 64'(0));
        finish_line(1, done_latency(n), 1'b1);

        // all-NUL line, no newline appended
        nn_valid_cnt = 0;
        nn_done_cnt  = 0;
        @(negedge clock);
        bus_nn.line_content = LINE_ZERO;
        bus_nn.line_valid   = 1'b1;
        @(negedge clock);
        bus_nn.line_valid   = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("nn_zero_valid", 64'(nn_valid_cnt), 64'(0));
        check_eq("nn_zero_done", 64'(nn_done_cnt), 64'(1));
        check_eq("nn_zero_count", 64'(bus_nn.char_count), 64'(0));
        bus_nn.line_content = LINE_V42;
        bus_nn.line_valid   = 1'b1;
        @(negedge clock);
        bus_nn.line_valid   = 1'b0;
        repeat (8) @(negedge clock);
        check_eq("nn_v42_valid", 64'(nn_valid_cnt), 64'(4));
        check_eq("nn_v42_done", 64'(nn_done_cnt), 64'(2));
        check_eq("nn_v42_count", 64'(bus_nn.char_count), 64'(4));

        // second line held during SEND
        n = push_line(LINE_V42, 1'b1);
        offer(LINE_V42);
        @(negedge clock);
        k = 2;
        bus.line_content = LINE_A7;
        bus.line_valid   = 1'b1;
        n = push_line(LINE_A7, 1'b1);
        while (!bus.line_done && k < 100) begin
            @(negedge clock);
            k++;
        end
        check_eq("t5_done_k", 64'(k), 64'(7));
        check_eq("t5_count", 64'(bus.char_count), 64'(5));
        @(negedge clock);
        check_eq("t5_idle_accept", 64'(bus.line_accept), 64'(1));
        @(negedge clock);
        bus.line_valid = 1'b0;
        check_eq("t5_first_char", 64'(bus.ascii_char), 64'(8'h41));
        check_eq("t5_first_valid", 64'(bus.char_valid), 64'(1));
        check_eq("t5_count_clr", 64'(bus.char_count), 64'(0));
        finish_line(4, done_latency(n), 1'b1);

        // reset mid-line after 3 characters
        n = push_line(LINE_ANGLE, 1'b1);
        offer(LINE_ANGLE);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        #1;
        check_eq("t6_valid", 64'(bus.char_valid), 64'(0));
        check_eq("t6_busy", 64'(bus.busy), 64'(0));
        check_eq("t6_accept", 64'(bus.line_accept), 64'(1));
        check_eq("t6_count", 64'(bus.char_count), 64'(0));
        repeat (3) @(negedge clock);
        check_eq("t6_no_done", 64'(done_cnt), 64'(d0));
        reset_n = 1'b1;
        n = push_line(LINE_V42, 1'b1);
        offer(LINE_V42);
        check_eq("t6_restart_char", 64'(bus.ascii_char), 64'(8'h56));
        finish_line(5, done_latency(n), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
